// File: rtl/led_blinker_multi.sv
// N-channel LED sequencer: shared tick prescaler plus per-channel OFF/ON/BLINK/ONESHOT engines
// with a run-time register write port and a global blink realignment strobe.
module led_blinker_multi #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 50000,
    parameter int PER_W      = 16,
    parameter int DEF_PERIOD = 500,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_mode,
    input  logic [PER_W-1:0]  wr_period,
    input  logic              sync_restart,
    output logic [N_CH-1:0]   LEDG,
    output logic [N_CH-1:0]   busy,
    output logic              tick_out
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_n;
    logic             tick_r;

    // Next prescaler value; tick_r mirrors "count is at its last value" as a flop.
    always_comb begin
        pre_n = pre_r;
        if (sync_restart) begin
            pre_n = {PRE_W{1'b0}};
        end else if (tick_r) begin
            pre_n = {PRE_W{1'b0}};
        end else begin
            pre_n = pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler and registered tick pulse.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_r  <= {PRE_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            pre_r  <= pre_n;
            tick_r <= (pre_n == PRE_W'(TICK_DIV - 1));
        end
    end

    assign tick_out = tick_r;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

        mode_t            mode_r, mode_n;
        logic [PER_W-1:0] period_r, period_n;
        logic [PER_W-1:0] cnt_r, cnt_n;
        logic [PER_W-1:0] last_s;
        logic             led_r, led_n;
        logic             busy_r, busy_n;
        logic             wr_hit_s;

        assign wr_hit_s = wr_en && (wr_ch == CH_IDX);
        // A zero period behaves as one tick, so the terminal count is 0 in that case.
        assign last_s   = (period_r == {PER_W{1'b0}}) ? {PER_W{1'b0}}
                                                      : period_r - {{(PER_W-1){1'b0}}, 1'b1};

        // Channel next-state: write beats realignment, realignment swallows the tick.
        always_comb begin
            mode_n   = mode_r;
            period_n = period_r;
            cnt_n    = cnt_r;
            led_n    = led_r;
            busy_n   = busy_r;
            if (wr_hit_s) begin
                mode_n   = mode_t'(wr_mode);
                period_n = wr_period;
                cnt_n    = {PER_W{1'b0}};
                led_n    = (wr_mode != 2'b00);
                busy_n   = (wr_mode == 2'b11);
            end else if (sync_restart) begin
                if (mode_r == MODE_BLINK) begin
                    cnt_n = {PER_W{1'b0}};
                    led_n = 1'b1;
                end else begin
                    cnt_n = cnt_r;
                end
            end else if (tick_r) begin
                case (mode_r)
                    MODE_BLINK: begin
                        if (cnt_r == last_s) begin
                            led_n = ~led_r;
                            cnt_n = {PER_W{1'b0}};
                        end else begin
                            cnt_n = cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_r == last_s) begin
                            led_n  = 1'b0;
                            busy_n = 1'b0;
                            mode_n = MODE_OFF;
                        end else begin
                            cnt_n = cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        cnt_n = cnt_r;
                    end
                endcase
            end else begin
                cnt_n = cnt_r;
            end
        end

        // Channel state register.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                mode_r   <= MODE_OFF;
                period_r <= PER_W'(DEF_PERIOD);
                cnt_r    <= {PER_W{1'b0}};
                led_r    <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                mode_r   <= mode_n;
                period_r <= period_n;
                cnt_r    <= cnt_n;
                led_r    <= led_n;
                busy_r   <= busy_n;
            end
        end

        assign LEDG[i] = led_r;
        assign busy[i] = busy_r;
    end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Randomized bench for led_blinker_multi against a tick-count reference model
// (LED state derived from elapsed ticks rather than from a toggle counter).
module tb_led_blinker_multi;
    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 4;
    localparam int PER_W      = 4;
    localparam int CH_W       = 3;
    localparam int DEF_PERIOD = 5;

    logic              CLOCK_50 = 1'b0;
    logic              RESET_N  = 1'b0;
    logic              wr_en    = 1'b0;
    logic [CH_W-1:0]   wr_ch    = '0;
    logic [1:0]        wr_mode  = '0;
    logic [PER_W-1:0]  wr_period = '0;
    logic              sync_restart = 1'b0;
    logic [N_CH-1:0]   LEDG;
    logic [N_CH-1:0]   busy;
    logic              tick_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode, effective period, ticks elapsed since (re)start, prescaler position.
    int m_mode [N_CH];
    int m_p    [N_CH];
    int m_el   [N_CH];
    int m_pre;

    led_blinker_multi #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .PER_W(PER_W),
        .DEF_PERIOD(DEF_PERIOD), .CH_W(CH_W)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_period(wr_period), .sync_restart(sync_restart),
        .LEDG(LEDG), .busy(busy), .tick_out(tick_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N_CH-1:0] exp_led();
        logic [N_CH-1:0] v;
        v = '0;
        for (int c = 0; c < N_CH; c++) begin
            case (m_mode[c])
                1:       v[c] = 1'b1;
                2:       v[c] = ((m_el[c] / m_p[c]) % 2) == 0;
                3:       v[c] = 1'b1;
                default: v[c] = 1'b0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_busy();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = (m_mode[c] == 3);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = 0;
            m_p[c]    = DEF_PERIOD;
            m_el[c]   = 0;
        end
        m_pre = 0;
    endtask

    task automatic model_step(input bit we, input int ch, input int md, input int per, input bit sy);
        bit tick;
        tick = (m_pre == TICK_DIV - 1);
        for (int c = 0; c < N_CH; c++) begin
            if (we && ch == c) begin
                m_mode[c] = md;
                m_p[c]    = (per == 0) ? 1 : per;
                m_el[c]   = 0;
            end else if (sy) begin
                if (m_mode[c] == 2) m_el[c] = 0;
            end else if (tick && m_mode[c] >= 2) begin
                m_el[c]++;
                if (m_mode[c] == 3 && m_el[c] >= m_p[c]) m_mode[c] = 0;
            end
        end
        m_pre = sy ? 0 : (m_pre + 1) % TICK_DIV;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic cycle(input bit we, input int ch, input int md, input int per, input bit sy);
        wr_en        = we;
        wr_ch        = CH_W'(ch);
        wr_mode      = 2'(md);
        wr_period    = PER_W'(per);
        sync_restart = sy;
        @(posedge CLOCK_50);
        model_step(we, ch, md, per, sy);
        @(negedge CLOCK_50);
        check_eq("ledg", 32'(LEDG), 32'(exp_led()));
        check_eq("busy", 32'(busy), 32'(exp_busy()));
        check_eq("tick_out", 32'(tick_out), 32'(m_pre == TICK_DIV - 1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int  k;
        bit  found;
        logic [N_CH-1:0] led_before;

        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_eq("reset_ledg", 32'(LEDG), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_tick", 32'(tick_out), 32'd0);
        RESET_N = 1'b1;

        for (int n = 1; n <= 8; n++) begin
            cycle(1'b0, 0, 0, 0, 1'b0);
            check_eq("tick_seq", 32'(tick_out), 32'((n % 4) == 3));
        end

        cycle(1'b1, 0, 2, 3, 1'b0);
        check_eq("ch0_blink_on", 32'(LEDG[0]), 32'd1);
        cycle(1'b1, 1, 3, 2, 1'b0);
        check_eq("ch1_shot_busy", 32'(busy[1]), 32'd1);
        cycle(1'b1, 2, 2, 0, 1'b0);
        idle(30);
        check_eq("ch1_shot_done", 32'({LEDG[1], busy[1]}), 32'd0);

        cycle(1'b1, 3, 2, 2, 1'b0);
        idle(7);
        cycle(1'b0, 0, 0, 0, 1'b1);
        check_eq("sync_leds", 32'({LEDG[3], LEDG[0]}), 32'b11);
        idle(20);

        k = 0;
        while (m_pre != TICK_DIV - 1 && k < 8) begin
            cycle(1'b0, 0, 0, 0, 1'b0);
            k++;
        end
        cycle(1'b1, 3, 2, 3, 1'b0);
        check_eq("ch3_restart", 32'(LEDG[3]), 32'd1);
        idle(4);

        led_before = LEDG;
        wr_en = 1'b1; wr_ch = 3'd4; wr_mode = 2'b00; wr_period = '0;
        @(posedge CLOCK_50);
        model_step(1'b1, 4, 0, 0, 1'b0);
        @(negedge CLOCK_50);
        check_eq("bad_ch_ledg", 32'(LEDG), 32'(exp_led()));
        check_eq("bad_ch_busy", 32'(busy), 32'(exp_busy()));

        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5), $urandom_range(0, 3),
                  $urandom_range(0, 4), $urandom_range(0, 49) == 0);
        end

        cycle(1'b1, 0, 2, 1, 1'b0);
        cycle(1'b1, 1, 3, 15, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (m_pre == TICK_DIV - 1 && exp_led() != '0) found = 1'b1;
            else cycle(1'b0, 0, 0, 0, 1'b0);
        end
        check_eq("reset_wait", 32'(found), 32'd1);
        check_eq("pre_reset_tick", 32'(tick_out), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("async_ledg", 32'(LEDG), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_tick", 32'(tick_out), 32'd0);
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
